// File: rtl/dual_issue_pkg.sv
// Shared opcode constants, instruction classes and decoded-field layout for the dual-issue scheduler.
package dual_issue_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_MEM  = 2'd1,
    CLS_CTRL = 2'd2
  } inst_cls_e;

  typedef struct packed {
    inst_cls_e        cls;
    logic [REG_W-1:0] dest;
    logic             dest_valid;
    logic [REG_W-1:0] src1;
    logic             src1_valid;
    logic [REG_W-1:0] src2;
    logic             src2_valid;
  } dec_t;

endpackage

// File: rtl/inst_classify.sv
// Combinational decode of one instruction into class plus destination/source registers.
// Register $0 is reported as not-valid so it never creates a dependency.
module inst_classify
  import dual_issue_pkg::*;
#(
  parameter int unsigned IW = 32
) (
  input  logic [IW-1:0] inst_i,
  output dec_t          dec_o
);

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;
  logic             unused_low;
  dec_t             dec;

  assign op         = inst_i[31:26];
  assign rs         = inst_i[25:21];
  assign rt         = inst_i[20:16];
  assign rd         = inst_i[15:11];
  assign unused_low = ^inst_i[10:0];

  always_comb begin
    dec     = '0;
    dec.cls = CLS_ALU;
    case (op)
      OP_RTYPE: begin
        dec.dest = rd; dec.dest_valid = 1'b1;
        dec.src1 = rs; dec.src1_valid = 1'b1;
        dec.src2 = rt; dec.src2_valid = 1'b1;
      end
      OP_ADDI: begin
        dec.dest = rt; dec.dest_valid = 1'b1;
        dec.src1 = rs; dec.src1_valid = 1'b1;
      end
      OP_LW: begin
        dec.cls  = CLS_MEM;
        dec.dest = rt; dec.dest_valid = 1'b1;
        dec.src1 = rs; dec.src1_valid = 1'b1;
      end
      OP_SW: begin
        dec.cls  = CLS_MEM;
        dec.src1 = rs; dec.src1_valid = 1'b1;
        dec.src2 = rt; dec.src2_valid = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec.cls  = CLS_CTRL;
        dec.src1 = rs; dec.src1_valid = 1'b1;
        dec.src2 = rt; dec.src2_valid = 1'b1;
      end
      OP_J:    dec.cls = CLS_CTRL;
      default: dec.cls = CLS_ALU;
    endcase
    dec.dest_valid = dec.dest_valid && (dec.dest != '0);
    dec.src1_valid = dec.src1_valid && (dec.src1 != '0);
    dec.src2_valid = dec.src2_valid && (dec.src2 != '0);
    dec_o = dec;
  end

endmodule

// File: rtl/dual_issue_sched.sv
// Instruction buffer and dual-lane issue scheduler (lane A: ALU/CTRL, lane B: MEM).
// Optional SCHED_STATS_EN adds saturating dual/single/stall issue counters.
module dual_issue_sched
  import dual_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 fetch_valid,
  input  logic [IW-1:0]              fetch_inst0,
  input  logic [IW-1:0]              fetch_inst1,
  output logic                       fetch_ready,
  input  logic                       issue_stall,
  input  logic                       flush,
  output logic                       issue_a_valid,
  output logic [IW-1:0]              issue_a_inst,
  output logic                       issue_b_valid,
  output logic [IW-1:0]              issue_b_inst,
  output logic [$clog2(DEPTH):0]     buf_count
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]                stat_dual,
  output logic [31:0]                stat_single,
  output logic [31:0]                stat_stall
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [IW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q;
  logic          a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic [IW-1:0] a_inst_q, a_inst_d, b_inst_q, b_inst_d;
  logic [1:0]    n_push, n_pop;
  logic [IW-1:0] h_inst, n_inst;
  dec_t          h_dec, n_dec;
  logic          raw, waw, pair_ok;
  logic          unused_h_src;

  assign h_inst = mem_q[rd_ptr_q];
  assign n_inst = mem_q[rd_ptr_q + PW'(1)];

  inst_classify #(.IW(IW)) u_cls_h (.inst_i(h_inst), .dec_o(h_dec));
  inst_classify #(.IW(IW)) u_cls_n (.inst_i(n_inst), .dec_o(n_dec));

  assign unused_h_src = ^{h_dec.src1, h_dec.src1_valid, h_dec.src2, h_dec.src2_valid};

  // Pairing rules: one MEM + one ALU, no CTRL, no RAW from H into N, no WAW.
  assign raw = h_dec.dest_valid &&
               ((n_dec.src1_valid && (n_dec.src1 == h_dec.dest)) ||
                (n_dec.src2_valid && (n_dec.src2 == h_dec.dest)));
  assign waw = h_dec.dest_valid && n_dec.dest_valid && (h_dec.dest == n_dec.dest);
  assign pair_ok = (count_q >= CW'(2)) &&
                   ((h_dec.cls == CLS_MEM) != (n_dec.cls == CLS_MEM)) &&
                   (h_dec.cls != CLS_CTRL) && (n_dec.cls != CLS_CTRL) && !raw && !waw;

  always_comb begin
    a_valid_d = a_valid_q;
    a_inst_d  = a_inst_q;
    b_valid_d = b_valid_q;
    b_inst_d  = b_inst_q;
    n_pop     = 2'd0;
    if (!issue_stall) begin
      a_valid_d = 1'b0;
      a_inst_d  = '0;
      b_valid_d = 1'b0;
      b_inst_d  = '0;
      if (pair_ok) begin
        n_pop     = 2'd2;
        a_valid_d = 1'b1;
        b_valid_d = 1'b1;
        if (h_dec.cls == CLS_MEM) begin
          b_inst_d = h_inst;
          a_inst_d = n_inst;
        end else begin
          a_inst_d = h_inst;
          b_inst_d = n_inst;
        end
      end else if (count_q != '0) begin
        n_pop = 2'd1;
        if (h_dec.cls == CLS_MEM) begin
          b_valid_d = 1'b1;
          b_inst_d  = h_inst;
        end else begin
          a_valid_d = 1'b1;
          a_inst_d  = h_inst;
        end
      end
    end
  end

  // Illegal 2'b10 pattern and pushes without room are dropped.
  always_comb begin
    n_push = 2'd0;
    if (ready_q) begin
      if (fetch_valid == 2'b11)      n_push = 2'd2;
      else if (fetch_valid == 2'b01) n_push = 2'd1;
    end
    count_d  = count_q + CW'(n_push) - CW'(n_pop);
    rd_ptr_d = rd_ptr_q + PW'(n_pop);
    wr_ptr_d = wr_ptr_q + PW'(n_push);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ready_q   <= 1'b1;
      a_valid_q <= 1'b0;
      a_inst_q  <= '0;
      b_valid_q <= 1'b0;
      b_inst_q  <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ready_q   <= (CW'(DEPTH) - count_d) >= CW'(2);
      a_valid_q <= a_valid_d;
      a_inst_q  <= a_inst_d;
      b_valid_q <= b_valid_d;
      b_inst_q  <= b_inst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (n_push != 2'd0) mem_q[wr_ptr_q] <= fetch_inst0;
      if (n_push == 2'd2) mem_q[wr_ptr_q + PW'(1)] <= fetch_inst1;
    end
  end

  assign fetch_ready   = ready_q;
  assign issue_a_valid = a_valid_q;
  assign issue_a_inst  = a_inst_q;
  assign issue_b_valid = b_valid_q;
  assign issue_b_inst  = b_inst_q;
  assign buf_count     = count_q;

`ifdef SCHED_STATS_EN
  logic [31:0] dual_q, single_q, stall_q;

  // Saturating counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      dual_q   <= '0;
      single_q <= '0;
      stall_q  <= '0;
    end else begin
      if (!flush && (n_pop == 2'd2) && (dual_q != '1))   dual_q   <= dual_q + 32'd1;
      if (!flush && (n_pop == 2'd1) && (single_q != '1)) single_q <= single_q + 32'd1;
      if (issue_stall && (count_q != '0) && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_dual   = dual_q;
  assign stat_single = single_q;
  assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_dual_issue_sched.sv
// Self-checking bench for dual_issue_sched: directed scenarios plus randomized traffic vs a queue model.
module tb_dual_issue_sched;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [1:0]  fetch_valid;
  logic [31:0] fetch_inst0, fetch_inst1;
  logic        fetch_ready;
  logic        issue_stall, flush;
  logic        issue_a_valid, issue_b_valid;
  logic [31:0] issue_a_inst, issue_b_inst;
  logic [2:0]  buf_count;
`ifdef SCHED_STATS_EN
  logic [31:0] stat_dual, stat_single, stat_stall;
`endif

  dual_issue_sched #(.DEPTH(DEPTH), .IW(32)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1),
    .fetch_ready(fetch_ready), .issue_stall(issue_stall), .flush(flush),
    .issue_a_valid(issue_a_valid), .issue_a_inst(issue_a_inst),
    .issue_b_valid(issue_b_valid), .issue_b_inst(issue_b_inst),
    .buf_count(buf_count)
`ifdef SCHED_STATS_EN
    , .stat_dual(stat_dual), .stat_single(stat_single), .stat_stall(stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: program-order queue plus expected lane outputs.
  logic [31:0] mq[$];
  logic        e_av, e_bv;
  logic [31:0] e_a, e_b;

  function automatic int m_cls(input logic [31:0] x);
    case (x[31:26])
      6'h23, 6'h2B:       return 1;
      6'h04, 6'h05, 6'h02: return 2;
      default:            return 0;
    endcase
  endfunction

  function automatic logic [4:0] m_dest(input logic [31:0] x);
    case (x[31:26])
      6'h00:        return x[15:11];
      6'h08, 6'h23: return x[20:16];
      default:      return 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] m_src1(input logic [31:0] x);
    case (x[31:26])
      6'h00, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h23: return x[25:21];
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] m_src2(input logic [31:0] x);
    case (x[31:26])
      6'h00, 6'h2B, 6'h04, 6'h05: return x[20:16];
      default: return 5'd0;
    endcase
  endfunction

  function automatic bit m_pairable(input logic [31:0] h, input logic [31:0] n);
    logic [4:0] d;
    d = m_dest(h);
    if ((m_cls(h) == 1) == (m_cls(n) == 1)) return 0;
    if (m_cls(h) == 2 || m_cls(n) == 2) return 0;
    if (d != 5'd0 && (d == m_src1(n) || d == m_src2(n))) return 0;
    if (d != 5'd0 && d == m_dest(n)) return 0;
    return 1;
  endfunction

  task automatic model_edge(input logic [1:0] fv, input logic [31:0] i0, input logic [31:0] i1,
                            input logic st, input logic fl, input logic r);
    bit ready;
    logic [31:0] h;
    if (r || fl) begin
      mq.delete();
      e_av = 0; e_bv = 0; e_a = 0; e_b = 0;
    end else begin
      ready = (DEPTH - mq.size()) >= 2;
      if (!st) begin
        e_av = 0; e_bv = 0; e_a = 0; e_b = 0;
        if (mq.size() >= 2 && m_pairable(mq[0], mq[1])) begin
          e_av = 1; e_bv = 1;
          if (m_cls(mq[0]) == 1) begin e_b = mq[0]; e_a = mq[1]; end
          else begin e_a = mq[0]; e_b = mq[1]; end
          void'(mq.pop_front()); void'(mq.pop_front());
        end else if (mq.size() >= 1) begin
          h = mq.pop_front();
          if (m_cls(h) == 1) begin e_bv = 1; e_b = h; end
          else begin e_av = 1; e_a = h; end
        end
      end
      if (ready) begin
        if (fv == 2'b11) begin mq.push_back(i0); mq.push_back(i1); end
        else if (fv == 2'b01) mq.push_back(i0);
      end
    end
  endtask

  // Drive one cycle's inputs, advance the model, and land #1 after the edge.
  task automatic step(input logic [1:0] fv, input logic [31:0] i0, input logic [31:0] i1,
                      input logic st, input logic fl, input logic r);
    fetch_valid = fv; fetch_inst0 = i0; fetch_inst1 = i1;
    issue_stall = st; flush = fl; rst = r;
    model_edge(fv, i0, i1, st, fl, r);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] ops [7];
    logic [5:0] op;
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
    op = ops[$urandom_range(0, 6)];
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            11'($urandom_range(0, 2047))};
  endfunction

  localparam logic [31:0] ADD   = 32'h00221820;
  localparam logic [31:0] LW45  = 32'h8CA40000;
  localparam logic [31:0] LW43  = 32'h8C640000;
  localparam logic [31:0] BEQ   = 32'h10220002;
  localparam logic [31:0] SW    = 32'hACC30004;

  task automatic test_reset();
    step(2'b00, 0, 0, 0, 0, 1);
    step(2'b11, ADD, LW45, 1, 0, 1);
    n_checks++; if (buf_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", buf_count); end
    n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", fetch_ready); end
    n_checks++; if (issue_a_valid !== 1'b0 || issue_b_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got a=%b b=%b exp 0 0", issue_a_valid, issue_b_valid); end
    n_checks++; if (issue_a_inst !== 32'd0 || issue_b_inst !== 32'd0) begin n_fail++; $display("FAIL reset_inst: got a=%h b=%h exp 0 0", issue_a_inst, issue_b_inst); end
  endtask

  task automatic test_pair();
    step(2'b11, ADD, LW45, 0, 0, 0);
    n_checks++; if (buf_count !== 3'd2 || issue_a_valid !== 1'b0) begin n_fail++; $display("FAIL pair_push: got count=%0d av=%b exp 2 0", buf_count, issue_a_valid); end
    step(2'b00, 0, 0, 0, 0, 0);
    n_checks++; if (issue_a_valid !== 1'b1 || issue_a_inst !== ADD) begin n_fail++; $display("FAIL pair_a: got %b/%h exp 1/%h", issue_a_valid, issue_a_inst, ADD); end
    n_checks++; if (issue_b_valid !== 1'b1 || issue_b_inst !== LW45) begin n_fail++; $display("FAIL pair_b: got %b/%h exp 1/%h", issue_b_valid, issue_b_inst, LW45); end
    n_checks++; if (buf_count !== 3'd0) begin n_fail++; $display("FAIL pair_count: got %0d exp 0", buf_count); end
  endtask

  task automatic test_raw();
    step(2'b11, ADD, LW43, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0);
    n_checks++; if (issue_a_valid !== 1'b1 || issue_a_inst !== ADD || issue_b_valid !== 1'b0) begin n_fail++; $display("FAIL raw_c1: got a=%b/%h b=%b exp 1/%h 0", issue_a_valid, issue_a_inst, issue_b_valid, ADD); end
    step(2'b00, 0, 0, 0, 0, 0);
    n_checks++; if (issue_b_valid !== 1'b1 || issue_b_inst !== LW43 || issue_a_valid !== 1'b0) begin n_fail++; $display("FAIL raw_c2: got b=%b/%h a=%b exp 1/%h 0", issue_b_valid, issue_b_inst, issue_a_valid, LW43); end
  endtask

  task automatic test_stats();
`ifdef SCHED_STATS_EN
    n_checks++; if (stat_dual !== 32'd1) begin n_fail++; $display("FAIL stat_dual: got %0d exp 1", stat_dual); end
    n_checks++; if (stat_single !== 32'd2) begin n_fail++; $display("FAIL stat_single: got %0d exp 2", stat_single); end
`endif
  endtask

  task automatic test_ctrl();
    step(2'b11, BEQ, SW, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0);
    n_checks++; if (issue_a_valid !== 1'b1 || issue_a_inst !== BEQ || issue_b_valid !== 1'b0) begin n_fail++; $display("FAIL ctrl_c1: got a=%b/%h b=%b exp 1/%h 0", issue_a_valid, issue_a_inst, issue_b_valid, BEQ); end
    step(2'b00, 0, 0, 0, 0, 0);
    n_checks++; if (issue_b_valid !== 1'b1 || issue_b_inst !== SW || issue_a_valid !== 1'b0) begin n_fail++; $display("FAIL ctrl_c2: got b=%b/%h a=%b exp 1/%h 0", issue_b_valid, issue_b_inst, issue_a_valid, SW); end
  endtask

  task automatic test_stall_full();
    logic [31:0] seq [4];
    seq = '{32'h20010001, 32'h20020002, 32'h20030003, 32'h20040004};
    step(2'b11, seq[0], seq[1], 1, 0, 0);
    step(2'b11, seq[2], seq[3], 1, 0, 0);
    n_checks++; if (buf_count !== 3'd4 || fetch_ready !== 1'b0) begin n_fail++; $display("FAIL full: got count=%0d ready=%b exp 4 0", buf_count, fetch_ready); end
    step(2'b11, 32'h20050005, 32'h20060006, 1, 0, 0);
    n_checks++; if (buf_count !== 3'd4) begin n_fail++; $display("FAIL full_drop: got %0d exp 4", buf_count); end
    n_checks++; if (issue_b_valid !== 1'b1 || issue_b_inst !== SW || issue_a_valid !== 1'b0) begin n_fail++; $display("FAIL stall_hold: got b=%b/%h a=%b exp 1/%h 0", issue_b_valid, issue_b_inst, issue_a_valid, SW); end
    for (int k = 0; k < 4; k++) begin
      step(2'b00, 0, 0, 0, 0, 0);
      n_checks++; if (issue_a_valid !== 1'b1 || issue_a_inst !== seq[k] || issue_b_valid !== 1'b0) begin n_fail++; $display("FAIL drain_%0d: got a=%b/%h exp 1/%h", k, issue_a_valid, issue_a_inst, seq[k]); end
      n_checks++; if (buf_count !== 3'(3 - k)) begin n_fail++; $display("FAIL drain_cnt_%0d: got %0d exp %0d", k, buf_count, 3 - k); end
    end
  endtask

  task automatic test_flush();
    step(2'b11, ADD, LW45, 0, 0, 0);
    step(2'b01, 32'h20050005, 0, 0, 0, 0);
    step(2'b11, 32'h20060006, 32'h20070007, 1, 0, 0);
    n_checks++; if (buf_count !== 3'd3 || issue_a_valid !== 1'b1 || issue_b_valid !== 1'b1) begin n_fail++; $display("FAIL preflush: got count=%0d av=%b bv=%b exp 3 1 1", buf_count, issue_a_valid, issue_b_valid); end
    step(2'b11, ADD, LW45, 1, 1, 0);
    n_checks++; if (buf_count !== 3'd0 || fetch_ready !== 1'b1) begin n_fail++; $display("FAIL flush_buf: got count=%0d ready=%b exp 0 1", buf_count, fetch_ready); end
    n_checks++; if (issue_a_valid !== 1'b0 || issue_b_valid !== 1'b0 || issue_a_inst !== 32'd0 || issue_b_inst !== 32'd0) begin n_fail++; $display("FAIL flush_out: got a=%b/%h b=%b/%h exp all 0", issue_a_valid, issue_a_inst, issue_b_valid, issue_b_inst); end
    step(2'b00, 0, 0, 0, 0, 0);
    n_checks++; if (issue_a_valid !== 1'b0 || issue_b_valid !== 1'b0 || buf_count !== 3'd0) begin n_fail++; $display("FAIL flush_drop: got av=%b bv=%b count=%0d exp 0 0 0", issue_a_valid, issue_b_valid, buf_count); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(2'($urandom_range(0, 3)), rand_inst(), rand_inst(),
           $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0);
      n_checks++; if (issue_a_valid !== e_av || issue_b_valid !== e_bv) begin n_fail++; $display("FAIL rnd_valid c%0d: got a=%b b=%b exp %b %b", c, issue_a_valid, issue_b_valid, e_av, e_bv); end
      if (e_av) begin n_checks++; if (issue_a_inst !== e_a) begin n_fail++; $display("FAIL rnd_a c%0d: got %h exp %h", c, issue_a_inst, e_a); end end
      if (e_bv) begin n_checks++; if (issue_b_inst !== e_b) begin n_fail++; $display("FAIL rnd_b c%0d: got %h exp %h", c, issue_b_inst, e_b); end end
      n_checks++; if (buf_count !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d exp %0d", c, buf_count, mq.size()); end
      n_checks++; if (fetch_ready !== ((DEPTH - mq.size()) >= 2)) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b exp %b", c, fetch_ready, (DEPTH - mq.size()) >= 2); end
    end
  endtask

  initial begin
    e_av = 0; e_bv = 0; e_a = 0; e_b = 0;
    test_reset();
    test_pair();
    test_raw();
    test_stats();
    test_ctrl();
    test_stall_full();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
